regfile_write_ctrl: RTL

Write-port front end for the register array built from enable-gated register cells. It accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO. It drains one request per cycle as a registered one-hot enable vector plus a shared data bus, which feed the En and D inputs of the register cells. A CLEAR command walks every register and writes zero.

---
 rtl/regfile_write_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl
//
// Write-port front end for a register array made of enable-gated register
// cells. Write requests are buffered in a 2-entry FIFO and drained one per
// cycle as a registered one-hot enable vector (EN) plus a shared data bus (WD).
// A CLEAR command walks every register index and writes zero; while it runs,
// the FIFO keeps accepting but does not drain.
//
// Handshake: a request transfers on a rising CK edge where WR_VALID and
// WR_READY are both high. WR_READY depends only on the registered FIFO count,
// never on WR_VALID, so the requester may hold WR_VALID/WR_ADDR/WR_DATA stable
// until it sees the transfer.
//
// Ports:
//   CK        in   clock, rising edge
//   RSTn      in   asynchronous active-low reset
//   WR_VALID  in   write request valid
//   WR_READY  out  FIFO not full
//   WR_ADDR   in   [AW-1:0]    target register index
//   WR_DATA   in   [WIDTH-1:0] write data
//   CLR_REQ   in   single-cycle pulse, start clear sequence
//   EN        out  [NREG-1:0]  registered one-hot (or zero) write enable
//   WD        out  [WIDTH-1:0] registered write data
//   BUSY      out  CLEAR active, FIFO non-empty or EN non-zero
//   ERR       out  sticky out-of-range address flag
//   DBG_STATE out  current FSM state (0 = IDLE, 1 = CLEAR)
// -----------------------------------------------------------------------------
module regfile_write_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             CK,
  input  logic             RSTn,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             CLR_REQ,
  output logic [NREG-1:0]  EN,
  output logic [WIDTH-1:0] WD,
  output logic             BUSY,
  output logic             ERR,
  output logic             DBG_STATE
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW:0]   NREG_X   = (AW + 1)'(NREG);

  // Out-of-range indices simply match no bit, giving an all-zero vector.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
    logic [NREG-1:0] res;
    res = '0;
    for (int i = 0; i < NREG; i++) begin
      res[i] = (idx == AW'(i));
    end
    return res;
  endfunction

  // FIFO storage
  logic [AW-1:0]    r_addr_mem [2];
  logic [WIDTH-1:0] r_data_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  // FSM and output registers
  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic [NREG-1:0]  r_en;
  logic [WIDTH-1:0] r_wd;
  logic             r_err;

  // Next-state wires
  state_t           w_state_nxt;
  logic [AW-1:0]    w_cnt_nxt;
  logic [NREG-1:0]  w_en_nxt;
  logic [WIDTH-1:0] w_wd_nxt;
  logic             w_err_set;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_head_addr;
  logic [WIDTH-1:0] w_head_data;
  logic             w_head_oor;

  assign WR_READY    = (r_count < 2'd2);
  assign w_push      = WR_VALID & WR_READY;
  assign w_head_addr = r_addr_mem[r_rd_ptr];
  assign w_head_data = r_data_mem[r_rd_ptr];
  assign w_head_oor  = ({1'b0, w_head_addr} >= NREG_X);

  // Next state, drain decision and next EN/WD. CLR_REQ in IDLE wins over a
  // pending pop so queued writes land after the zeros.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = '0;
    w_wd_nxt    = r_wd;
    w_err_set   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CLR_REQ) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else if (r_count != 2'd0) begin
          w_pop     = 1'b1;
          w_en_nxt  = onehot(w_head_addr);
          w_wd_nxt  = w_head_data;
          w_err_set = w_head_oor;
        end
      end
      S_CLEAR: begin
        w_en_nxt = onehot(r_cnt);
        w_wd_nxt = '0;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_en    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_wd    <= w_wd_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // FIFO: a pop and a push in the same cycle leave the count unchanged.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_addr_mem[0] <= '0;
      r_addr_mem[1] <= '0;
      r_data_mem[0] <= '0;
      r_data_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_addr_mem[r_wr_ptr] <= WR_ADDR;
        r_data_mem[r_wr_ptr] <= WR_DATA;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign EN        = r_en;
  assign WD        = r_wd;
  assign ERR       = r_err;
  assign BUSY      = (r_state == S_CLEAR) | (r_count != 2'd0) | (|r_en);
  assign DBG_STATE = r_state;

endmodule
